// File: rtl/philv_pkg.sv
// Shared definitions for the philv fetch stage: FSM states, PC step and reset vector.
package philv_pkg;

    typedef enum logic [1:0] {
        StReset,
        StReq,
        StHold,
        StDrain
    } fetch_state_e;

    localparam int unsigned PC_STEP              = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect target select: jump beats branch, target forced word aligned, raw misalignment flagged.
module pc_next_sel #(
    parameter int unsigned N = 32
) (
    input  logic         i_branch,
    input  logic [N-1:0] i_branch_target,
    input  logic         i_jump,
    input  logic [N-1:0] i_jump_target,
    output logic         o_redir,
    output logic [N-1:0] o_target,
    output logic         o_misaligned
);

    logic [N-1:0] w_raw;

    always_comb begin
        w_raw        = i_jump ? i_jump_target : i_branch_target;
        o_redir      = i_jump | i_branch;
        o_target     = {w_raw[N-1:2], 2'b00};
        o_misaligned = o_redir & (|w_raw[1:0]);
    end

endmodule

// File: rtl/fetch_redirect_pc.sv
// PC and instruction-fetch stage: one outstanding imem request, IF/ID valid/stall handshake,
// redirect with flush and stale-response drain.
module fetch_redirect_pc
    import philv_pkg::*;
#(
    parameter int unsigned  N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(RESET_VECTOR_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         branch,
    input  logic [N-1:0] branchTarget,
    input  logic         jump,
    input  logic [N-1:0] jumpTarget,
    input  logic         stall,
    output logic         imemReq,
    output logic [N-1:0] imemAddr,
    input  logic         imemValid,
    input  logic [31:0]  imemData,
    output logic [N-1:0] pcOut,
    output logic [31:0]  instrOut,
    output logic         instrValid,
    output logic         flush,
    output logic         misaligned
);

    fetch_state_e r_state;
    logic [N-1:0] r_fetch_pc;
    logic         r_req;
    logic [N-1:0] r_pc_out;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic         r_flush;
    logic         r_mis;

    logic         w_redir;
    logic [N-1:0] w_target;
    logic         w_mis;
    logic [N-1:0] w_pc_inc;

    pc_next_sel #(
        .N (N)
    ) u_pc_next_sel (
        .i_branch        (branch),
        .i_branch_target (branchTarget),
        .i_jump          (jump),
        .i_jump_target   (jumpTarget),
        .o_redir         (w_redir),
        .o_target        (w_target),
        .o_misaligned    (w_mis)
    );

    // Modulo 2^N wrap is intended.
    assign w_pc_inc = r_fetch_pc + N'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StReset;
            r_fetch_pc <= RESET_VECTOR;
            r_req      <= 1'b0;
            r_pc_out   <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_flush    <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_mis   <= 1'b0;
            unique case (r_state)
                StReset: begin
                    r_state <= StReq;
                    r_req   <= 1'b1;
                end
                StReq: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        r_flush    <= 1'b1;
                        r_mis      <= w_mis;
                        r_valid    <= 1'b0;
                        // Without a response this cycle it is still owed and must be dropped.
                        if (imemValid) begin
                            r_state <= StReq;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= StDrain;
                            r_req   <= 1'b0;
                        end
                    end else if (imemValid) begin
                        r_instr  <= imemData;
                        r_pc_out <= r_fetch_pc;
                        r_valid  <= 1'b1;
                        if (!stall) begin
                            r_fetch_pc <= w_pc_inc;
                        end else begin
                            r_state <= StHold;
                            r_req   <= 1'b0;
                        end
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                StHold: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        r_flush    <= 1'b1;
                        r_mis      <= w_mis;
                        r_valid    <= 1'b0;
                        r_state    <= StReq;
                        r_req      <= 1'b1;
                    end else if (!stall) begin
                        r_fetch_pc <= w_pc_inc;
                        r_valid    <= 1'b0;
                        r_state    <= StReq;
                        r_req      <= 1'b1;
                    end
                end
                StDrain: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        r_flush    <= 1'b1;
                        r_mis      <= w_mis;
                        r_valid    <= 1'b0;
                    end
                    if (imemValid) begin
                        r_state <= StReq;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StReset;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imemReq    = r_req;
    assign imemAddr   = r_fetch_pc;
    assign pcOut      = r_pc_out;
    assign instrOut   = r_instr;
    assign instrValid = r_valid;
    assign flush      = r_flush;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_fetch_redirect_pc.sv
// Directed self-checking bench for fetch_redirect_pc with hand-computed expectations.
module tb_fetch_redirect_pc;

    logic        clk;
    logic        rst;
    logic        branch;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        stall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemData;
    logic [31:0] pcOut;
    logic [31:0] instrOut;
    logic        instrValid;
    logic        flush;
    logic        misaligned;

    logic        auto_mem;
    logic        man_valid;
    logic [31:0] man_data;

    int checks;
    int failures;

    // Zero-wait memory answers in the request cycle; data derived from the address.
    assign imemValid = auto_mem ? imemReq : man_valid;
    assign imemData  = auto_mem ? (imemAddr ^ 32'hA5A5_0000) : man_data;

    fetch_redirect_pc #(
        .N            (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .stall        (stall),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemValid    (imemValid),
        .imemData     (imemData),
        .pcOut        (pcOut),
        .instrOut     (instrOut),
        .instrValid   (instrValid),
        .flush        (flush),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; branch = 1'b0; jump = 1'b0; stall = 1'b0;
        branchTarget = '0; jumpTarget = '0;
        auto_mem = 1'b0; man_valid = 1'b0; man_data = '0;
        step();
        step();
        checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imemReq); end
        checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imemAddr); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instrValid); end
        checks++; if ({flush, misaligned} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {flush, misaligned}); end
        checks++; if ({pcOut, instrOut} !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {pcOut, instrOut}); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        auto_mem = 1'b1;
        step();
        checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL seq_first_req got=%b exp=1", imemReq); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL seq_c1_valid got=%b exp=0", instrValid); end
        step();
        checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL seq_c2_valid got=%b exp=1", instrValid); end
        checks++; if (pcOut !== 32'h0) begin failures++; $display("FAIL seq_c2_pc got=%h exp=0", pcOut); end
        checks++; if (instrOut !== 32'hA5A5_0000) begin failures++; $display("FAIL seq_c2_instr got=%h exp=a5a50000", instrOut); end
        checks++; if (imemAddr !== 32'h4) begin failures++; $display("FAIL seq_c2_addr got=%h exp=4", imemAddr); end
        step();
        checks++; if (imemAddr !== 32'h8) begin failures++; $display("FAIL seq_c3_addr got=%h exp=8", imemAddr); end
        checks++; if (pcOut !== 32'h4) begin failures++; $display("FAIL seq_c3_pc got=%h exp=4", pcOut); end
        step();
        checks++; if (imemAddr !== 32'hC) begin failures++; $display("FAIL seq_c4_addr got=%h exp=c", imemAddr); end
        checks++; if (instrOut !== 32'hA5A5_0008) begin failures++; $display("FAIL seq_c4_instr got=%h exp=a5a50008", instrOut); end
    endtask

    task automatic test_stall();
        auto_mem = 1'b0; man_valid = 1'b1; man_data = 32'h0050_0093; stall = 1'b1;
        step();
        man_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instrOut !== 32'h0050_0093) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=00500093", i, instrOut); end
            checks++; if (pcOut !== 32'hC) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=c", i, pcOut); end
            checks++; if ({imemReq, instrValid} !== 2'b01) begin failures++; $display("FAIL stall_req_valid[%0d] got=%b exp=01", i, {imemReq, instrValid}); end
            checks++; if (imemAddr !== 32'hC) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=c", i, imemAddr); end
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        checks++; if (imemAddr !== 32'h10) begin failures++; $display("FAIL stall_release_addr got=%h exp=10", imemAddr); end
        checks++; if ({imemReq, instrValid} !== 2'b10) begin failures++; $display("FAIL stall_release_req_valid got=%b exp=10", {imemReq, instrValid}); end
    endtask

    task automatic test_branch_drain();
        branch = 1'b1; branchTarget = 32'h100;
        step();
        branch = 1'b0;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", flush); end
        checks++; if (imemAddr !== 32'h100) begin failures++; $display("FAIL br_addr got=%h exp=100", imemAddr); end
        checks++; if ({imemReq, misaligned} !== 2'b00) begin failures++; $display("FAIL br_req_mis got=%b exp=00", {imemReq, misaligned}); end
        step();
        checks++; if ({flush, imemReq} !== 2'b00) begin failures++; $display("FAIL br_flush_once got=%b exp=00", {flush, imemReq}); end
        man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
        step();
        man_valid = 1'b0;
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL br_stale_dropped got=%b exp=0", instrValid); end
        checks++; if ({imemReq, imemAddr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL br_new_req got=%h exp=100000100", {imemReq, imemAddr}); end
        man_valid = 1'b1; man_data = 32'h1111_1111;
        step();
        man_valid = 1'b0;
        checks++; if ({instrValid, pcOut, instrOut} !== {1'b1, 32'h100, 32'h1111_1111}) begin failures++; $display("FAIL br_capture got=%h exp=10000010011111111", {instrValid, pcOut, instrOut}); end
        checks++; if (imemAddr !== 32'h104) begin failures++; $display("FAIL br_next_addr got=%h exp=104", imemAddr); end
        step();
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL br_valid_clear got=%b exp=0", instrValid); end
    endtask

    task automatic test_jump_priority();
        jump = 1'b1; jumpTarget = 32'h200; branch = 1'b1; branchTarget = 32'h100;
        step();
        jump = 1'b0; branch = 1'b0;
        checks++; if (imemAddr !== 32'h200) begin failures++; $display("FAIL jp_addr got=%h exp=200", imemAddr); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jp_flush got=%b exp=1", flush); end
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        checks++; if ({imemReq, instrValid} !== 2'b10) begin failures++; $display("FAIL jp_after_drain got=%b exp=10", {imemReq, instrValid}); end
    endtask

    task automatic test_misaligned();
        jump = 1'b1; jumpTarget = 32'h102;
        step();
        jump = 1'b0;
        checks++; if ({misaligned, flush} !== 2'b11) begin failures++; $display("FAIL mis_pulse got=%b exp=11", {misaligned, flush}); end
        checks++; if (imemAddr !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=100", imemAddr); end
        step();
        checks++; if ({misaligned, flush} !== 2'b00) begin failures++; $display("FAIL mis_once got=%b exp=00", {misaligned, flush}); end
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        checks++; if ({imemReq, imemAddr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL mis_req got=%h exp=100000100", {imemReq, imemAddr}); end
    endtask

    task automatic test_wrap();
        auto_mem = 1'b1;
        jump = 1'b1; jumpTarget = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        checks++; if ({imemReq, imemAddr} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_redir got=%h exp=1fffffffc", {imemReq, imemAddr}); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL wrap_flush_valid got=%b exp=0", instrValid); end
        step();
        checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imemAddr); end
        checks++; if ({instrValid, pcOut} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_pc got=%h exp=1fffffffc", {instrValid, pcOut}); end
        step();
        checks++; if ({pcOut, imemAddr} !== {32'h0, 32'h4}) begin failures++; $display("FAIL wrap_continue got=%h exp=4", {pcOut, imemAddr}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_drain();
        test_jump_priority();
        test_misaligned();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
